truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
- Sequential characterizer for a combinational logic block of N_IN inputs (e.g. the 3-input, mux-based function cells).
- Walks the block's input vector through every minterm, 0 to 2^N_IN-1, waits a settle time, samples the block's output and assembles the full truth table.
- Compares the assembled table against an expected table and reports match/mismatch.
- Serves as the self-check/readback companion to the table-driven function cells: a table goes in, a function comes out; this block recovers the table from the function.

Parameters:
- N_IN, 3, number of function inputs; TABLE_W = 2**N_IN.
- SETTLE, 1, cycles each minterm is held before sampling (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  scan request; accepted only in IDLE.
- expected  input  TABLE_W  expected truth table; bit i = output for minterm i; latched on accepted start.
- fn_in  output  N_IN  drives the function's inputs; MSB = first input, e.g. {a,b,c}.
- fn_y  input  1  function output under test.
- table_out  output  TABLE_W  captured truth table; bit i = fn_y sampled for minterm i.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse: scan complete, table_out final.
- match  output  1  table_out == latched expected; valid while result_valid is set.

Behaviour:
- Reset (async, any state): state=IDLE; fn_in=0, table_out=0, expected latch=0, settle counter=0, busy=0, done=0, match=0, result_valid=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - fn_in=0.
  - start=1 at a rising edge: latch expected, clear table_out, clear result_valid, idx=0, settle counter=0, go to SCAN.
- SCAN:
  - fn_in=idx, driven from a register.
  - The settle counter counts 0..SETTLE-1. At the edge where counter==SETTLE-1: table_out[idx] <= fn_y and the counter resets.
  - If idx==TABLE_W-1 at that edge: go to DONE and set result_valid. Otherwise idx <= idx+1.
  - Each minterm is therefore presented for exactly SETTLE cycles, and fn_y is sampled at the last edge of that window.
  - Only bit idx of table_out changes per sample; the other bits hold.
- DONE: held for exactly one cycle. done=1, busy=1, fn_in holds TABLE_W-1, then go to IDLE.
- Latency: done is high in the cycle beginning TABLE_W*SETTLE edges after the edge that accepted start.
- match:
  - match = result_valid & (table_out == expected_latched).
  - Stays valid and stable in IDLE until the next accepted start or reset.
- busy = (state != IDLE).
- start while in SCAN or DONE is ignored. No queuing; it must be re-issued in IDLE.
- A change on expected while not in IDLE has no effect.
- Reset mid-scan aborts immediately. The partial table is discarded (table_out=0) and no done pulse is produced.
- idx width = N_IN. The idx increment never wraps because the scan ends at TABLE_W-1.
- All outputs come from registers or state decode only; no combinational path from fn_y to any output.

Test Plan:
- Nominal scan, SETTLE=1, N_IN=3:
  - Stimulus: fn_y = the 3-input function with table 0,0,0,1,0,1,1,1 (minterms 0..7); expected=8'hE8; pulse start.
  - Required response: fn_in steps 0..7, one cycle each. done pulses 8 cycles after the start edge. table_out=8'hE8, match=1, busy low the cycle after done.
- Mismatch: same function, expected=8'hE9 -> table_out=8'hE8, match=0 with done; match stays 0 in IDLE.
- Settle timing, SETTLE=3:
  - Stimulus: fn_y = fn_in[0] delayed 2 cycles through a register pipe.
  - Required response: each fn_in value is held exactly 3 cycles. table_out=8'hAA, done 24 cycles after the start edge.
- Start while busy:
  - Stimulus: extra start pulses at scan cycles 2 and 5, and in the DONE cycle.
  - Required response: scan is unaffected, a single done pulse, no second scan until start in IDLE.
- Reset mid-scan:
  - Stimulus: assert reset asynchronously (off-edge) during minterm 4.
  - Required response: all outputs 0 immediately, no done. A fresh start afterwards completes normally with table_out=8'hE8.
- Back-to-back scans:
  - Stimulus: start on the first IDLE cycle after done, with expected changed to 8'h17 and fn_y inverted.
  - Required response: match cleared on accept; second done gives table_out=8'h17, match=1.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Characterizes a N_IN-input combinational block by stepping through every minterm and capturing its output.
// done asserts TABLE_W*SETTLE edges after start is accepted; start is ignored (not queued) while busy.
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  localparam int TABLE_W = 2**N_IN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TABLE_W-1:0] expected,
  output logic [N_IN-1:0]    fn_in,
  input  logic               fn_y,
  output logic [TABLE_W-1:0] table_out,
  output logic               busy,
  output logic               done,
  output logic               match
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TABLE_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [N_IN-1:0]    idx;
  logic [CW-1:0]      settle_cnt;
  logic [TABLE_W-1:0] table_q;
  logic [TABLE_W-1:0] exp_q;
  logic               result_valid;
  logic               accept;
  logic               sample;
  logic               last;

  assign accept = (state == IDLE) && start;
  assign sample = (state == SCAN) && (settle_cnt == CNT_LAST);
  assign last   = sample && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SCAN:    busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // fn_y is only ever sampled into table_q, so no output depends on it combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      settle_cnt   <= '0;
      table_q      <= '0;
      exp_q        <= '0;
      result_valid <= 1'b0;
    end else begin
      if (accept) begin
        exp_q        <= expected;
        table_q      <= '0;
        result_valid <= 1'b0;
        idx          <= '0;
        settle_cnt   <= '0;
      end
      if (state == SCAN) begin
        if (sample) begin
          table_q[idx] <= fn_y;
          settle_cnt   <= '0;
          if (last) begin
            result_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end
      // idx holds TABLE_W-1 through DONE, then returns to 0 so fn_in idles low.
      if (state == DONE) begin
        idx <= '0;
      end
    end
  end

  assign fn_in     = idx;
  assign table_out = table_q;
  assign match     = result_valid && (table_q == exp_q);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: one instance at SETTLE=1, one at SETTLE=3, scoreboard-checked done events.
module tb_truth_table_scanner;

  localparam int TW = 8;

  typedef struct {
    logic [7:0] tab;
    logic       m;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic [7:0] expected1, expected3;
  logic [2:0] fn_in1, fn_in3;
  logic       fn_y1, fn_y3;
  logic [7:0] table_out1, table_out3;
  logic       busy1, busy3, done1, done3, match1, match3;
  logic       inv1;
  logic       p0 = 1'b0, p1 = 1'b0;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Function under test for instance 1: 3-input majority, optionally inverted.
  assign fn_y1 = ((fn_in1[2] & fn_in1[1]) | (fn_in1[2] & fn_in1[0]) | (fn_in1[1] & fn_in1[0])) ^ inv1;

  // Function for instance 3: fn_in[0] delayed two cycles.
  always @(posedge clk) begin
    p0 <= fn_in3[0];
    p1 <= p0;
  end
  assign fn_y3 = p1;

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .expected(expected1),
    .fn_in(fn_in1), .fn_y(fn_y1), .table_out(table_out1),
    .busy(busy1), .done(done1), .match(match1)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .expected(expected3),
    .fn_in(fn_in3), .fn_y(fn_y3), .table_out(table_out3),
    .busy(busy3), .done(done3), .match(match3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_table", {24'd0, table_out1}, {24'd0, e1.tab});
        check("dut1_match", {31'd0, match1}, {31'd0, e1.m});
        check("dut1_done_cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done3) begin
      if (q3.size() == 0) begin
        check("dut3_unexpected_done", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        check("dut3_table", {24'd0, table_out3}, {24'd0, e3.tab});
        check("dut3_match", {31'd0, match3}, {31'd0, e3.m});
        check("dut3_done_cycle", cyc, e3.cyc);
      end
    end
  end

  // Leaves the caller at #1 after the accepting edge.
  task automatic start_scan1(input logic [7:0] exp_tab, input logic [7:0] model_tab,
                             input logic model_m, input bit push);
    exp_t e;
    expected1 = exp_tab;
    start1    = 1'b1;
    tick();
    start1    = 1'b0;
    expected1 = 8'h00;
    e.tab = model_tab;
    e.m   = model_m;
    e.cyc = cyc + TW * 1;
    if (push) q1.push_back(e);
  endtask

  task automatic wait_done1(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done1) return;
      tick();
    end
    check("dut1_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    expected1 = 8'h00; expected3 = 8'h00; inv1 = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_fn_in", {29'd0, fn_in1}, 32'd0);
    check("rst_table", {24'd0, table_out1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_match", {31'd0, match1}, 32'd0);
    reset = 1'b0;
    tick();

    // Nominal scan: majority function, table E8
    start_scan1(8'hE8, 8'hE8, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check("nom_fn_in", {29'd0, fn_in1}, k);
      check("nom_busy", {31'd0, busy1}, 32'd1);
      check("nom_no_done", {31'd0, done1}, 32'd0);
      tick();
    end
    check("nom_done", {31'd0, done1}, 32'd1);
    check("nom_done_fn_in", {29'd0, fn_in1}, 32'd7);
    tick();
    check("nom_busy_low", {31'd0, busy1}, 32'd0);
    check("nom_idle_match", {31'd0, match1}, 32'd1);
    check("nom_idle_table", {24'd0, table_out1}, 32'hE8);
    check("nom_idle_fn_in", {29'd0, fn_in1}, 32'd0);

    // Mismatch against E9
    start_scan1(8'hE9, 8'hE8, 1'b0, 1'b1);
    wait_done1(40);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mis_idle_match", {31'd0, match1}, 32'd0);
    end

    // Start while busy: pulses at scan cycles 2 and 5 and in DONE
    start_scan1(8'hE8, 8'hE8, 1'b1, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      start1 = (c == 2 || c == 5 || c == 8);
      if (c == 8) check("busy_start_done_cycle", {31'd0, done1}, 32'd1);
      tick();
    end
    start1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("busy_start_no_rescan", {31'd0, busy1}, 32'd0);
      tick();
    end

    // Reset mid-scan during minterm 4
    start_scan1(8'hE8, 8'hE8, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("abort_minterm", {29'd0, fn_in1}, 32'd4);
    #2 reset = 1'b1;
    #1;
    check("abort_fn_in", {29'd0, fn_in1}, 32'd0);
    check("abort_table", {24'd0, table_out1}, 32'd0);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_done", {31'd0, done1}, 32'd0);
    check("abort_match", {31'd0, match1}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    start_scan1(8'hE8, 8'hE8, 1'b1, 1'b1);
    wait_done1(40);

    // Back-to-back: restart on the first IDLE cycle with inverted function
    tick();
    check("b2b_idle_match", {31'd0, match1}, 32'd1);
    inv1 = 1'b1;
    start_scan1(8'h17, 8'h17, 1'b1, 1'b1);
    check("b2b_match_cleared", {31'd0, match1}, 32'd0);
    check("b2b_table_cleared", {24'd0, table_out1}, 32'd0);
    wait_done1(40);
    tick();
    check("b2b_table", {24'd0, table_out1}, 32'h17);
    check("b2b_match", {31'd0, match1}, 32'd1);
    inv1 = 1'b0;

    // Settle timing at SETTLE=3
    expected3 = 8'hAA;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    begin
      exp_t e;
      e.tab = 8'hAA; e.m = 1'b1; e.cyc = cyc + TW * 3;
      q3.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 3; r++) begin
        check("s3_fn_in_hold", {29'd0, fn_in3}, k);
        tick();
      end
    end
    check("s3_done", {31'd0, done3}, 32'd1);
    tick();
    check("s3_busy_low", {31'd0, busy3}, 32'd0);

    tick(); tick();
    check("q1_drained", q1.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
